// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, next-PC select and a three-state
// IDLE/REQ/DONE fetch sequencer that loads the instruction register.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_start,
  input  logic                        pc_write,
  input  logic [1:0]                  pc_src,
  input  logic [31:0]                 branch_target,
  input  logic [31:0]                 jump_target,
  input  logic [31:0]                 reg_target,
  instruction_fetch_unit_if.master    mem,
  output logic [31:0]                 instr,
  output logic                        instr_valid,
  output logic [31:0]                 pc_out,
  output logic [31:0]                 pc_plus4,
  output logic [25:0]                 immediate,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] ir_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] sel_pc_s;
  logic        pc_load_s;
  logic        ir_load_s;

  assign pc_plus4_s = pc_r + 32'd4;
  // PC is frozen during REQ so the memory sees one stable address per request.
  assign pc_load_s  = pc_write && (state_r != REQ);
  assign ir_load_s  = (state_r == REQ) && mem.mem_ack;

  // Fetch sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; fetch_start outside IDLE is dropped, not queued.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fetch_start) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          next_state_s = DONE;
        end else begin
          next_state_s = REQ;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next-PC source select.
  always_comb begin
    sel_pc_s = pc_plus4_s;
    case (pc_src)
      2'b00:   sel_pc_s = pc_plus4_s;
      2'b01:   sel_pc_s = branch_target;
      2'b10:   sel_pc_s = jump_target;
      2'b11:   sel_pc_s = reg_target;
      default: sel_pc_s = pc_plus4_s;
    endcase
  end

  // PC register; targets are word-aligned by clearing the low two bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC_ALIGNED;
    end else if (pc_load_s) begin
      pc_r <= {sel_pc_s[31:2], 2'b00};
    end
  end

  // Instruction register, loaded only on the edge that completes a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_r <= 32'h0000_0000;
    end else if (ir_load_s) begin
      ir_r <= mem.mem_rdata;
    end
  end

  // Handshake outputs decode the state register only, so reset clears them at once.
  assign mem.mem_req  = (state_r == REQ);
  assign mem.mem_addr = pc_r;
  assign instr_valid  = (state_r == DONE);
  assign busy         = (state_r != IDLE);
  assign instr        = ir_r;
  assign immediate    = ir_r[25:0];
  assign pc_out       = pc_r;
  assign pc_plus4     = pc_plus4_s;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; low two bits SHALL be 00.
REQ-002 CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 SHALL force reset state immediately, independent of CLK.
REQ-004 fetch_start  input  1  control-unit request to fetch the instruction at current PC.
REQ-005 pc_write  input  1  load next PC at this edge.
REQ-006 pc_src  input  2  next-PC select: 00 PC+4, 01 branch_target, 10 jump_target, 11 reg_target.
REQ-007 branch_target  input  32  branch address from branch adder.
REQ-008 jump_target  input  32  J-type target from the jump-address stage ({PC+4[31:28], imm26, 00}).
REQ-009 reg_target  input  32  JR register value.
REQ-010 mem_req  output  1  instruction-memory read request.
REQ-011 mem_addr  output  32  read address; SHALL equal pc_out.
REQ-012 mem_ack  input  1  memory read data valid.
REQ-013 mem_rdata  input  32  memory read data.
REQ-014 instr  output  32  instruction register (IR).
REQ-015 instr_valid  output  1  one-cycle pulse: IR newly loaded.
REQ-016 pc_out  output  32  current PC register.
REQ-017 pc_plus4  output  32  combinational pc_out+4, mod 2^32; feeds the jump-address stage as its PC input.
REQ-018 immediate  output  26  combinational instr[25:0]; feeds the jump-address stage.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states IDLE, REQ, DONE; IDLE->REQ on fetch_start; REQ->DONE on edge with mem_ack=1; REQ holds while mem_ack=0; DONE->IDLE unconditionally.
REQ-021 mem_req SHALL be 1 exactly while state is REQ (registered state decode, no combinational path from fetch_start).
REQ-022 On the edge leaving REQ, IR SHALL load mem_rdata; IR SHALL hold otherwise.
REQ-023 instr_valid SHALL be 1 exactly while state is DONE.
REQ-024 Latency: fetch_start sampled at edge N with mem_ack tied high -> mem_req high in cycle N+1, instr_valid high in cycle N+2; each wait cycle with mem_ack=0 adds one cycle.
REQ-025 fetch_start outside IDLE SHALL be ignored (not queued).
REQ-026 mem_ack outside REQ SHALL be ignored; IR unchanged.
REQ-027 pc_write in IDLE or DONE SHALL load PC from the pc_src-selected source with bits [1:0] forced to 00.
REQ-028 pc_write in REQ SHALL be ignored, so mem_addr is stable for the whole request.
REQ-029 Simultaneous fetch_start and pc_write in IDLE: PC SHALL update and the fetch SHALL use the new PC.
REQ-030 PC+4 from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 without error indication.

Reset
REQ-031 While Reset=0: state IDLE, PC=RESET_PC, IR=0, mem_req=0, instr_valid=0, busy=0; pc_plus4=RESET_PC+4, immediate=0.
REQ-032 Reset asserted mid-fetch (REQ or DONE) SHALL drop mem_req and instr_valid without waiting for CLK; a later mem_ack SHALL not load IR.
REQ-033 After Reset deasserts, the first fetch SHALL require a new fetch_start.

Verification
REQ-034 Reset, then fetch_start pulse, mem_ack tied 1, mem_rdata=32'h0800_0010 -> mem_addr=0, mem_req high one cycle, instr=32'h0800_0010, immediate=26'h000_0010, instr_valid one cycle at N+2.
REQ-035 Fetch with mem_ack delayed 3 cycles -> mem_req high 4 cycles, mem_addr constant; pc_write pulses during wait leave pc_out unchanged.
REQ-036 PC=32'h0000_0040, pc_write with pc_src=00/01/10/11 and targets 32'h100/32'h0040_0200/32'h1000_0003 -> pc_out 32'h44, 32'h100, 32'h0040_0200, 32'h1000_0000.
REQ-037 PC=32'hFFFF_FFFC, pc_write pc_src=00 -> pc_out=0, pc_plus4=4.
REQ-038 Reset pulled low in REQ between edges -> mem_req falls immediately; mem_ack next cycle leaves instr=0 and pc_out=RESET_PC.
REQ-039 fetch_start and pc_write (pc_src=10, jump_target=32'h0000_0080) same edge in IDLE -> mem_addr=32'h80 during REQ.
